// File: rtl/bus_seq_pkg.sv
// Shared types and constants for the bus source sequencer.
// Used by the sequencer top and its priority encoder.
package bus_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

   localparam int NSRC_DEF = 32;
   localparam int SELW_DEF = 5;
   localparam int TMO_W    = 8;

endpackage

// File: rtl/prio_enc32.sv
// Lowest-set-bit encoder: mask in, index plus any-set flag out.
// Purely combinational.
module prio_enc32
   import bus_seq_pkg::*;
#(
   parameter int NSRC = NSRC_DEF,
   parameter int SELW = SELW_DEF
) (
   input  logic [NSRC-1:0] mask,
   output logic [SELW-1:0] idx,
   output logic            any
);

   // Scan from the top down so the lowest set bit is written last.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = SELW'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_source_sequencer.sv
// Walks a batch of bus-drive requests in ascending order, one grant
// at a time, with a per-grant watchdog that skips silent consumers.
module bus_source_sequencer
   import bus_seq_pkg::*;
#(
   parameter int NSRC = NSRC_DEF,
   parameter int SELW = SELW_DEF,
   parameter int TMO  = 15
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic            req_valid,
   input  logic [NSRC-1:0] req_mask,
   output logic            req_ready,
   output logic [SELW-1:0] sel,
   output logic            sel_valid,
   input  logic            bus_ack,
   input  logic            abort,
   output logic            done,
   output logic            tmo_flag,
   output logic [SELW-1:0] tmo_src
);

   seq_state_t       state;
   logic [NSRC-1:0]  pend;
   logic [NSRC-1:0]  pend_nxt;
   logic [TMO_W-1:0] cnt;
   logic             grant_end;
   logic             timeout;
   logic [SELW-1:0]  nxt_idx;
   logic             nxt_any;

   // Encoding the next pending mask lets sel update with no bubble.
   prio_enc32 #(
      .NSRC (NSRC),
      .SELW (SELW)
   ) u_enc (
      .mask (pend_nxt),
      .idx  (nxt_idx),
      .any  (nxt_any)
   );

   always_comb begin
      pend_nxt  = pend;
      grant_end = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) pend_nxt = req_mask;
         end
         ISSUE: begin
            if (abort) begin
               pend_nxt = '0;
            end else begin
               if (bus_ack) begin
                  grant_end = 1'b1;
               end else if (cnt == TMO_W'(TMO - 1)) begin
                  grant_end = 1'b1;
                  timeout   = 1'b1;
               end
               if (grant_end) pend_nxt = pend & ~(NSRC'(1) << sel);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= IDLE;
         pend      <= '0;
         cnt       <= '0;
         sel       <= '0;
         sel_valid <= 1'b0;
         req_ready <= 1'b1;
         done      <= 1'b0;
         tmo_flag  <= 1'b0;
         tmo_src   <= '0;
      end else begin
         pend <= pend_nxt;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  tmo_flag  <= 1'b0;
                  cnt       <= '0;
                  req_ready <= 1'b0;
                  if (nxt_any) begin
                     state     <= ISSUE;
                     sel       <= nxt_idx;
                     sel_valid <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (abort) begin
                  state     <= IDLE;
                  sel_valid <= 1'b0;
                  req_ready <= 1'b1;
                  cnt       <= '0;
               end else if (grant_end) begin
                  cnt <= '0;
                  if (timeout) begin
                     tmo_flag <= 1'b1;
                     tmo_src  <= sel;
                  end
                  if (nxt_any) begin
                     sel <= nxt_idx;
                  end else begin
                     state     <= DONE;
                     sel_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               sel_valid <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_source_sequencer.sv
// Self-checking bench: directed scenarios plus random batches checked
// against a grant-by-grant model of the sequencing rules.
module tb_bus_source_sequencer;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        req_valid;
   logic [31:0] req_mask;
   logic        req_ready;
   logic [4:0]  sel;
   logic        sel_valid;
   logic        bus_ack;
   logic        abort;
   logic        done;
   logic        tmo_flag;
   logic [4:0]  tmo_src;

   int total = 0;
   int fails = 0;
   int dly_tab[32];
   logic       exp_flag = 1'b0;
   logic [4:0] exp_src  = '0;

   bus_source_sequencer #(.NSRC(32), .SELW(5), .TMO(TMO)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .req_valid (req_valid),
      .req_mask  (req_mask),
      .req_ready (req_ready),
      .sel       (sel),
      .sel_valid (sel_valid),
      .bus_ack   (bus_ack),
      .abort     (abort),
      .done      (done),
      .tmo_flag  (tmo_flag),
      .tmo_src   (tmo_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: sources are served lowest-first; a source whose ack comes
   // d cycles into its grant holds sel for d+1 cycles, or TMO cycles
   // and is flagged if d >= TMO.
   task automatic run_batch(input logic [31:0] m);
      int srcs[$];
      int n;
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(req_ready), 1);
      chk("flag_hold", 32'(tmo_flag), 32'(exp_flag));
      req_valid = 1'b1;
      req_mask  = m;
      @(negedge clk);
      req_valid = 1'b0;
      req_mask  = $urandom;
      exp_flag  = 1'b0;
      for (int i = 0; i < 32; i++) if (m[i]) srcs.push_back(i);
      foreach (srcs[j]) begin
         for (int k = 0; k < TMO; k++) begin
            chk("grant_valid", 32'(sel_valid), 1);
            chk("grant_sel", 32'(sel), 32'(srcs[j]));
            chk("grant_done", 32'(done), 0);
            chk("grant_ready", 32'(req_ready), 0);
            chk("grant_flag", 32'(tmo_flag), 32'(exp_flag));
            if (k == dly_tab[srcs[j]]) begin
               bus_ack = 1'b1;
               @(negedge clk);
               bus_ack = 1'b0;
               break;
            end
            @(negedge clk);
            if (k == TMO - 1) begin
               exp_flag = 1'b1;
               exp_src  = 5'(srcs[j]);
            end
         end
      end
      chk("end_valid", 32'(sel_valid), 0);
      chk("end_done", 32'(done), 1);
      chk("end_ready", 32'(req_ready), 0);
      chk("end_flag", 32'(tmo_flag), 32'(exp_flag));
      chk("end_src", 32'(tmo_src), 32'(exp_src));
      @(negedge clk);
      chk("post_done", 32'(done), 0);
      chk("post_ready", 32'(req_ready), 1);
   endtask

   initial begin
      logic [31:0] m;
      clr_n     = 1'b0;
      req_valid = 1'b0;
      req_mask  = '0;
      bus_ack   = 1'b0;
      abort     = 1'b0;
      #12;
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_valid", 32'(sel_valid), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_flag", 32'(tmo_flag), 0);
      chk("rst_src", 32'(tmo_src), 0);
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);

      // Single source, ack two cycles into the grant.
      foreach (dly_tab[i]) dly_tab[i] = 2;
      run_batch(32'h0000_0010);

      // Three sources acked immediately: back-to-back grants.
      foreach (dly_tab[i]) dly_tab[i] = 0;
      run_batch(32'h8000_0005);

      // Source 1 never acked, source 2 acked at once.
      dly_tab[1] = 99;
      dly_tab[2] = 0;
      run_batch(32'h0000_0006);

      // Ack on the very edge the watchdog would fire.
      dly_tab[3] = TMO - 1;
      run_batch(32'h0000_0008);

      // Empty batch.
      run_batch(32'h0);

      // Abort together with ack on the first grant.
      req_valid = 1'b1;
      req_mask  = 32'h0000_00F0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_sel", 32'(sel), 4);
      abort   = 1'b1;
      bus_ack = 1'b1;
      @(negedge clk);
      abort   = 1'b0;
      bus_ack = 1'b0;
      chk("abort_valid", 32'(sel_valid), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_ready", 32'(req_ready), 1);
      chk("abort_flag", 32'(tmo_flag), 32'(exp_flag));
      @(negedge clk);
      chk("abort_done2", 32'(done), 0);

      // Random batches with a spread of ack delays.
      for (int b = 0; b < 24; b++) begin
         foreach (dly_tab[i]) dly_tab[i] = $urandom_range(0, 18);
         m = $urandom & $urandom & $urandom;
         if (b % 8 == 7) m = '0;
         run_batch(m);
      end

      // Asynchronous reset between clock edges mid-grant.
      req_valid = 1'b1;
      req_mask  = 32'h0000_0F00;
      @(negedge clk);
      req_valid = 1'b0;
      chk("arst_pre_sel", 32'(sel), 8);
      #2 clr_n = 1'b0;
      #1;
      exp_flag = 1'b0;
      exp_src  = '0;
      chk("arst_valid", 32'(sel_valid), 0);
      chk("arst_sel", 32'(sel), 0);
      chk("arst_ready", 32'(req_ready), 1);
      chk("arst_flag", 32'(tmo_flag), 0);
      @(negedge clk);
      clr_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("arst_nodone", 32'(done), 0);
         chk("arst_idle", 32'(sel_valid), 0);
      end

      foreach (dly_tab[i]) dly_tab[i] = 1;
      run_batch(32'h4000_0001);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
